// File: rtl/reaction_timer.sv
// ---------------------------------------------------------------------------
// reaction_timer
//
// Measures a player's reaction time against the F1 start-light bar. Once
// every light has been lit and the bar then goes dark, a millisecond counter
// runs until the player presses the button. The elapsed time is reported in
// milliseconds. A press while the lights are still lit is a jump start.
//
// Optional feature macro: REACTION_TIMER_BEST_EN
//   defined     -> best_ms tracks the smallest valid reaction since reset
//                  (reset value all ones)
//   not defined -> best_ms is tied to 0
//
// Parameters:
//   N_LEDS        width of the light bar
//   TIME_WIDTH    width of the millisecond counter and results
//   CYCLES_PER_MS clk cycles per millisecond tick (>= 2)
//
// Ports:
//   clk           single clock, rising edge
//   rst           asynchronous reset, active low
//   lights        light bar from f1_fsm, synchronous to clk
//   press         raw player button, asynchronous level
//   clear         synchronous acknowledge of a result or a fault
//   reaction_ms   last latched reaction time
//   result_valid  high while reaction_ms holds a fresh result (DONE)
//   jump_start    high while in FAULT
//   busy          high in ARMED or TIMING
//   best_ms       best valid reaction since reset (0 without the macro)
// ---------------------------------------------------------------------------
module reaction_timer #(
    parameter int N_LEDS        = 8,
    parameter int TIME_WIDTH    = 16,
    parameter int CYCLES_PER_MS = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_LEDS-1:0]     lights,
    input  logic                  press,
    input  logic                  clear,
    output logic [TIME_WIDTH-1:0] reaction_ms,
    output logic                  result_valid,
    output logic                  jump_start,
    output logic                  busy,
    output logic [TIME_WIDTH-1:0] best_ms
);

    localparam int                 PRESC_W    = $clog2(CYCLES_PER_MS);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CYCLES_PER_MS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_TIMING,
        S_DONE,
        S_FAULT
    } state_t;

    // Millisecond count never wraps back to zero; it sticks at all ones.
    function automatic logic [TIME_WIDTH-1:0] sat_inc(input logic [TIME_WIDTH-1:0] v);
        return (&v) ? v : v + TIME_WIDTH'(1);
    endfunction

    state_t                state_q, state_d;
    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    logic                  sync3_q, sync3_d;
    logic [N_LEDS-1:0]     lights_prev_q, lights_prev_d;
    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic [TIME_WIDTH-1:0] count_q, count_d;
    logic                  seen_full_q, seen_full_d;
    logic [TIME_WIDTH-1:0] reaction_q, reaction_d;
    logic                  result_valid_q, result_valid_d;
    logic                  jump_start_q, jump_start_d;
    logic                  busy_q, busy_d;

    logic press_evt;
    logic start;
    logic full;
    logic lights_zero;

    // sync1/sync2 resolve metastability; sync3 holds the previous synced
    // level so a held button yields a single one-cycle event.
    assign press_evt   = sync2_q & ~sync3_q;
    assign lights_zero = ~(|lights);
    assign start       = (|lights) & ~(|lights_prev_q);
    assign full        = &lights;

    always_comb begin
        sync1_d       = press;
        sync2_d       = sync1_q;
        sync3_d       = sync2_q;
        lights_prev_d = lights;

        state_d     = state_q;
        presc_d     = presc_q;
        count_d     = count_q;
        seen_full_d = seen_full_q;
        reaction_d  = reaction_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_ARMED;
                    seen_full_d = 1'b0;
                end
            end

            S_ARMED: begin
                // A press while any light is lit is a jump start, whatever
                // the lights are doing in the same cycle.
                if (press_evt) begin
                    state_d = S_FAULT;
                end else if (lights_zero) begin
                    if (seen_full_q) begin
                        state_d = S_TIMING;
                        presc_d = '0;
                        count_d = '0;
                    end else begin
                        // Bar went dark before ever being full: aborted run.
                        state_d = S_IDLE;
                    end
                end else if (full) begin
                    seen_full_d = 1'b1;
                end
            end

            S_TIMING: begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    count_d = sat_inc(count_q);
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end

                // Latch the count as it stood before this edge's increment.
                if (press_evt) begin
                    state_d    = S_DONE;
                    reaction_d = count_q;
                end else if (start) begin
                    state_d     = S_ARMED;
                    seen_full_d = 1'b0;
                end
            end

            S_DONE, S_FAULT: begin
                // A new sequence takes priority over the acknowledge.
                if (start) begin
                    state_d     = S_ARMED;
                    seen_full_d = 1'b0;
                end else if (clear) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered copies of the next state.
        result_valid_d = (state_d == S_DONE);
        jump_start_d   = (state_d == S_FAULT);
        busy_d         = (state_d == S_ARMED) || (state_d == S_TIMING);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            sync3_q        <= 1'b0;
            lights_prev_q  <= '0;
            presc_q        <= '0;
            count_q        <= '0;
            seen_full_q    <= 1'b0;
            reaction_q     <= '0;
            result_valid_q <= 1'b0;
            jump_start_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            sync3_q        <= sync3_d;
            lights_prev_q  <= lights_prev_d;
            presc_q        <= presc_d;
            count_q        <= count_d;
            seen_full_q    <= seen_full_d;
            reaction_q     <= reaction_d;
            result_valid_q <= result_valid_d;
            jump_start_q   <= jump_start_d;
            busy_q         <= busy_d;
        end
    end

    assign reaction_ms  = reaction_q;
    assign result_valid = result_valid_q;
    assign jump_start   = jump_start_q;
    assign busy         = busy_q;

`ifdef REACTION_TIMER_BEST_EN
    logic [TIME_WIDTH-1:0] best_q, best_d;

    // Updated on the same edge that latches a valid reaction; faults never
    // reach this path.
    always_comb begin
        best_d = best_q;
        if ((state_q == S_TIMING) && press_evt && (count_q < best_q)) begin
            best_d = count_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_q <= '1;
        end else begin
            best_q <= best_d;
        end
    end

    assign best_ms = best_q;
`else
    assign best_ms = '0;
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// ---------------------------------------------------------------------------
// tb_reaction_timer
//
// Two instances: u_dut (8 LEDs, 16-bit time, 10 cycles/ms) carries most of
// the scenarios; u_sat (4-bit time, 2 cycles/ms) covers saturation. The
// reference model reasons only in terms of when the raw press rises relative
// to the edge that entered TIMING.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reaction_timer;

    localparam int CPM   = 10;
    localparam int TW    = 16;
    localparam int S_CPM = 2;
    localparam int S_TW  = 4;

`ifdef REACTION_TIMER_BEST_EN
    localparam bit BEST_EN = 1'b1;
`else
    localparam bit BEST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  lights;
    logic        press;
    logic        clear;
    logic [15:0] reaction_ms;
    logic        result_valid;
    logic        jump_start;
    logic        busy;
    logic [15:0] best_ms;

    logic [7:0]  s_lights;
    logic        s_press;
    logic        s_clear;
    logic [3:0]  s_ms;
    logic        s_valid;
    logic        s_jump;
    logic        s_busy;
    logic [3:0]  s_best;

    int n_checks = 0;
    int n_pass   = 0;
    int best_model;
    int last_ms;
    int s_best_model;

    always #5 clk = ~clk;

    reaction_timer #(.N_LEDS(8), .TIME_WIDTH(TW), .CYCLES_PER_MS(CPM)) u_dut (
        .clk(clk), .rst(rst), .lights(lights), .press(press), .clear(clear),
        .reaction_ms(reaction_ms), .result_valid(result_valid),
        .jump_start(jump_start), .busy(busy), .best_ms(best_ms)
    );

    reaction_timer #(.N_LEDS(8), .TIME_WIDTH(S_TW), .CYCLES_PER_MS(S_CPM)) u_sat (
        .clk(clk), .rst(rst), .lights(s_lights), .press(s_press), .clear(s_clear),
        .reaction_ms(s_ms), .result_valid(s_valid),
        .jump_start(s_jump), .busy(s_busy), .best_ms(s_best)
    );

    // Raw press set up before edge T0+d (T0 = edge entering TIMING) passes two
    // synchroniser stages and is acted on at edge T0+d+2, which reports
    // floor((d+1)/cpm) milliseconds, clamped to the counter's maximum.
    function automatic int model_ms(input int d, input int cpm, input int tw);
        int v;
        int vmax;
        v    = (d + 1) / cpm;
        vmax = (1 << tw) - 1;
        return (v > vmax) ? vmax : v;
    endfunction

    function automatic logic [15:0] exp_best();
        return BEST_EN ? 16'(best_model) : 16'h0000;
    endfunction

    function automatic logic [3:0] exp_s_best();
        return BEST_EN ? 4'(s_best_model) : 4'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic note_result(input int v);
        last_ms = v;
        if (v < best_model) best_model = v;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        best_model   = 65535;
        s_best_model = 15;
        last_ms      = 0;
        tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
    endtask

    // Ramp 0x01..0xFF, hold each step, then go dark; returns just after T0.
    task automatic light_seq(input int hold);
        for (int i = 1; i <= 8; i++) begin
            lights = 8'((1 << i) - 1);
            repeat (hold) tick();
        end
        lights = 8'h00;
        tick();
    endtask

    task automatic timed_run(input int hold, input int d);
        light_seq(hold);
        repeat (d - 1) tick();
        press = 1'b1;
        repeat (3) tick();
        press = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        best_model = 65535; s_best_model = 15; last_ms = 0;
        n_checks++; if (reaction_ms !== 16'h0) $display("FAIL reset_reaction got %0d want 0", reaction_ms); else n_pass++;
        n_checks++; if (result_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", result_valid); else n_pass++;
        n_checks++; if (jump_start !== 1'b0) $display("FAIL reset_jump got %b want 0", jump_start); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (best_ms !== exp_best()) $display("FAIL reset_best got %0h want %0h", best_ms, exp_best()); else n_pass++;
        n_checks++; if (s_best !== exp_s_best()) $display("FAIL reset_s_best got %0h want %0h", s_best, exp_s_best()); else n_pass++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_normal();
        int exp_v;
        light_seq(2);
        n_checks++; if (busy !== 1'b1) $display("FAIL normal_busy_timing got %b want 1", busy); else n_pass++;
        repeat (247) tick();
        press = 1'b1;
        repeat (3) tick();
        press = 1'b0;
        exp_v = model_ms(248, CPM, TW);
        note_result(exp_v);
        n_checks++; if (reaction_ms !== 16'(exp_v)) $display("FAIL normal_reaction got %0d want %0d", reaction_ms, exp_v); else n_pass++;
        n_checks++; if (result_valid !== 1'b1) $display("FAIL normal_valid got %b want 1", result_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL normal_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (jump_start !== 1'b0) $display("FAIL normal_jump got %b want 0", jump_start); else n_pass++;
        n_checks++; if (best_ms !== exp_best()) $display("FAIL normal_best got %0d want %0d", best_ms, exp_best()); else n_pass++;
        do_clear();
        n_checks++; if (result_valid !== 1'b0) $display("FAIL normal_clear_valid got %b want 0", result_valid); else n_pass++;
        n_checks++; if (reaction_ms !== 16'(last_ms)) $display("FAIL normal_hold got %0d want %0d", reaction_ms, last_ms); else n_pass++;
    endtask

    task automatic test_random_runs();
        int hold;
        int d;
        int exp_v;
        for (int r = 0; r < 6; r++) begin
            hold  = int'($urandom_range(1, 3));
            d     = int'($urandom_range(1, 400));
            timed_run(hold, d);
            exp_v = model_ms(d, CPM, TW);
            note_result(exp_v);
            n_checks++; if (reaction_ms !== 16'(exp_v)) $display("FAIL random_reaction d=%0d got %0d want %0d", d, reaction_ms, exp_v); else n_pass++;
            n_checks++; if (result_valid !== 1'b1) $display("FAIL random_valid d=%0d got %b want 1", d, result_valid); else n_pass++;
            n_checks++; if (best_ms !== exp_best()) $display("FAIL random_best d=%0d got %0d want %0d", d, best_ms, exp_best()); else n_pass++;
            do_clear();
        end
    endtask

    task automatic test_jump_start();
        int step;
        for (int r = 0; r < 2; r++) begin
            step = (r == 0) ? 3 : int'($urandom_range(1, 8));
            for (int i = 1; i <= step; i++) begin
                lights = 8'((1 << i) - 1);
                tick();
            end
            press = 1'b1;
            repeat (3) tick();
            n_checks++; if (jump_start !== 1'b1) $display("FAIL jump_flag step=%0d got %b want 1", step, jump_start); else n_pass++;
            n_checks++; if (result_valid !== 1'b0) $display("FAIL jump_valid got %b want 0", result_valid); else n_pass++;
            n_checks++; if (busy !== 1'b0) $display("FAIL jump_busy got %b want 0", busy); else n_pass++;
            press  = 1'b0;
            lights = 8'h00;
            tick();
            do_clear();
            n_checks++; if (jump_start !== 1'b0) $display("FAIL jump_clear_flag got %b want 0", jump_start); else n_pass++;
            n_checks++; if (busy !== 1'b0) $display("FAIL jump_clear_busy got %b want 0", busy); else n_pass++;
            n_checks++; if (reaction_ms !== 16'(last_ms)) $display("FAIL jump_reaction got %0d want %0d", reaction_ms, last_ms); else n_pass++;
            n_checks++; if (best_ms !== exp_best()) $display("FAIL jump_best got %0d want %0d", best_ms, exp_best()); else n_pass++;
        end
    endtask

    task automatic test_abort();
        for (int i = 1; i <= 4; i++) begin
            lights = 8'((1 << i) - 1);
            tick();
        end
        lights = 8'h00;
        tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else n_pass++;
        repeat (15) tick();
        press = 1'b1;
        repeat (4) tick();
        press = 1'b0;
        n_checks++; if (result_valid !== 1'b0) $display("FAIL abort_valid got %b want 0", result_valid); else n_pass++;
        n_checks++; if (jump_start !== 1'b0) $display("FAIL abort_jump got %b want 0", jump_start); else n_pass++;
        n_checks++; if (reaction_ms !== 16'(last_ms)) $display("FAIL abort_reaction got %0d want %0d", reaction_ms, last_ms); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        int exp_v;
        timed_run(1, 35);
        exp_v = model_ms(35, CPM, TW);
        note_result(exp_v);
        n_checks++; if (result_valid !== 1'b1) $display("FAIL b2b_done_valid got %b want 1", result_valid); else n_pass++;
        // New sequence and acknowledge on the same edge.
        lights = 8'h01;
        clear  = 1'b1;
        tick();
        clear  = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("FAIL b2b_busy got %b want 1", busy); else n_pass++;
        n_checks++; if (result_valid !== 1'b0) $display("FAIL b2b_valid got %b want 0", result_valid); else n_pass++;
        n_checks++; if (reaction_ms !== 16'(exp_v)) $display("FAIL b2b_reaction got %0d want %0d", reaction_ms, exp_v); else n_pass++;
        for (int i = 2; i <= 8; i++) begin
            lights = 8'((1 << i) - 1);
            tick();
        end
        lights = 8'h00;
        tick();
        repeat (20) tick();
        // Restart from TIMING: back to ARMED with no result.
        lights = 8'h01;
        tick();
        n_checks++; if (busy !== 1'b1) $display("FAIL restart_busy got %b want 1", busy); else n_pass++;
        n_checks++; if (result_valid !== 1'b0) $display("FAIL restart_valid got %b want 0", result_valid); else n_pass++;
        lights = 8'h00;
        tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL restart_abort_busy got %b want 0", busy); else n_pass++;
        tick();
    endtask

    task automatic test_best();
        int ds[3];
        int exp_v;
        ds[0] = 300; ds[1] = 200; ds[2] = 250;
        do_reset();
        n_checks++; if (best_ms !== exp_best()) $display("FAIL best_reset got %0h want %0h", best_ms, exp_best()); else n_pass++;
        for (int r = 0; r < 3; r++) begin
            timed_run(1, ds[r]);
            exp_v = model_ms(ds[r], CPM, TW);
            note_result(exp_v);
            n_checks++; if (reaction_ms !== 16'(exp_v)) $display("FAIL best_reaction got %0d want %0d", reaction_ms, exp_v); else n_pass++;
            n_checks++; if (best_ms !== exp_best()) $display("FAIL best_value run=%0d got %0d want %0d", r, best_ms, exp_best()); else n_pass++;
            do_clear();
        end
        lights = 8'h01;
        tick();
        press = 1'b1;
        repeat (3) tick();
        press  = 1'b0;
        lights = 8'h00;
        n_checks++; if (jump_start !== 1'b1) $display("FAIL best_jump got %b want 1", jump_start); else n_pass++;
        n_checks++; if (best_ms !== exp_best()) $display("FAIL best_after_jump got %0d want %0d", best_ms, exp_best()); else n_pass++;
        tick();
        do_clear();
    endtask

    task automatic test_saturation();
        int ds[2];
        int exp_v;
        ds[0] = 100; ds[1] = 7;
        for (int r = 0; r < 2; r++) begin
            s_lights = 8'h01; tick();
            s_lights = 8'hFF; tick();
            s_lights = 8'h00; tick();
            repeat (ds[r] - 1) tick();
            s_press = 1'b1;
            repeat (3) tick();
            s_press = 1'b0;
            exp_v = model_ms(ds[r], S_CPM, S_TW);
            if (exp_v < s_best_model) s_best_model = exp_v;
            n_checks++; if (s_ms !== 4'(exp_v)) $display("FAIL sat_reaction d=%0d got %0d want %0d", ds[r], s_ms, exp_v); else n_pass++;
            n_checks++; if (s_valid !== 1'b1) $display("FAIL sat_valid got %b want 1", s_valid); else n_pass++;
            n_checks++; if (s_busy !== 1'b0) $display("FAIL sat_busy got %b want 0", s_busy); else n_pass++;
            n_checks++; if (s_best !== exp_s_best()) $display("FAIL sat_best got %0d want %0d", s_best, exp_s_best()); else n_pass++;
            s_clear = 1'b1; tick();
            s_clear = 1'b0; tick();
        end
    endtask

    task automatic test_async_reset();
        int exp_v;
        light_seq(1);
        repeat (30) tick();
        n_checks++; if (busy !== 1'b1) $display("FAIL areset_pre_busy got %b want 1", busy); else n_pass++;
        #3;
        rst = 1'b0;
        #1;
        best_model = 65535; s_best_model = 15; last_ms = 0;
        n_checks++; if (reaction_ms !== 16'h0) $display("FAIL areset_reaction got %0d want 0", reaction_ms); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL areset_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (result_valid !== 1'b0) $display("FAIL areset_valid got %b want 0", result_valid); else n_pass++;
        n_checks++; if (jump_start !== 1'b0) $display("FAIL areset_jump got %b want 0", jump_start); else n_pass++;
        n_checks++; if (best_ms !== exp_best()) $display("FAIL areset_best got %0h want %0h", best_ms, exp_best()); else n_pass++;
        n_checks++; if (s_ms !== 4'h0) $display("FAIL areset_s_ms got %0d want 0", s_ms); else n_pass++;
        // Button held through reset release must not become an event.
        press = 1'b1;
        #2;
        rst = 1'b1;
        repeat (5) tick();
        light_seq(1);
        repeat (4) tick();
        n_checks++; if (busy !== 1'b1) $display("FAIL held_busy got %b want 1", busy); else n_pass++;
        n_checks++; if (jump_start !== 1'b0) $display("FAIL held_jump got %b want 0", jump_start); else n_pass++;
        press = 1'b0;
        repeat (4) tick();
        press = 1'b1;
        repeat (3) tick();
        press = 1'b0;
        exp_v = model_ms(9, CPM, TW);
        note_result(exp_v);
        n_checks++; if (result_valid !== 1'b1) $display("FAIL repress_valid got %b want 1", result_valid); else n_pass++;
        n_checks++; if (reaction_ms !== 16'(exp_v)) $display("FAIL repress_reaction got %0d want %0d", reaction_ms, exp_v); else n_pass++;
        n_checks++; if (best_ms !== exp_best()) $display("FAIL repress_best got %0d want %0d", best_ms, exp_best()); else n_pass++;
        do_clear();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst      = 1'b0;
        lights   = 8'h00;
        press    = 1'b0;
        clear    = 1'b0;
        s_lights = 8'h00;
        s_press  = 1'b0;
        s_clear  = 1'b0;
        best_model   = 65535;
        s_best_model = 15;
        last_ms      = 0;

        test_reset();
        test_normal();
        test_random_runs();
        test_jump_start();
        test_abort();
        test_back_to_back();
        test_best();
        test_saturation();
        test_async_reset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
